softmax_normalizer: RTL

//  Final softmax stage after the e^x / row-sum engine: buffers one row of N_ELEM UQ3.6 e^x values,

---
 rtl/softmax_normalizer_pkg.sv | 33 +++
 rtl/softmax_normalizer_if.sv | 26 ++
 rtl/softmax_normalizer_serial_udiv.sv | 95 +++++++++
 rtl/softmax_normalizer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/softmax_normalizer_pkg.sv
// Shared types and sizing for the softmax normalizer.
// The widths are common with the upstream e^x stage so both agree on formats:
//   e^x values are UQ3.6, probabilities are UQ0.OUT_W.
package softmax_normalizer_pkg;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) begin
        result = result + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  localparam int N_ELEM = 4;              // e^x values per row
  localparam int EX_W   = 9;              // UQ3.6 e^x width
  localparam int SUM_W  = 11;             // row-sum width
  localparam int OUT_W  = 8;              // UQ0.8 probability width
  localparam int IDX_W  = clog2(N_ELEM);  // element index width
  localparam int CNT_W  = clog2(OUT_W);   // divider bit counter width

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DIVIDE  = 2'd1,
    OUTPUT  = 2'd2
  } norm_state_t;

endpackage

// File: rtl/softmax_normalizer_if.sv
// Stream interface of the softmax normalizer.
//   ex_in/ex_vld/ex_rdy              : e^x input stream (UQ3.6)
//   prob_out/prob_vld/prob_rdy/last : probability output stream (UQ0.8)
// master = the environment (drives e^x, accepts probabilities), slave = the normalizer.
interface softmax_normalizer_if;
  import softmax_normalizer_pkg::*;

  logic [EX_W-1:0]  ex_in;
  logic             ex_vld;
  logic             ex_rdy;
  logic [OUT_W-1:0] prob_out;
  logic             prob_vld;
  logic             prob_rdy;
  logic             prob_last;

  modport master (
    output ex_in, ex_vld, prob_rdy,
    input  ex_rdy, prob_out, prob_vld, prob_last
  );

  modport slave (
    input  ex_in, ex_vld, prob_rdy,
    output ex_rdy, prob_out, prob_vld, prob_last
  );

endinterface

// File: rtl/softmax_normalizer_serial_udiv.sv
// Serial restoring divider producing floor(num * 2^OUT_W / den), one quotient bit per cycle.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   start      : load cycle; evaluates zero/saturate shortcuts or arms the iterations
//   num        : dividend (e^x value), den : divisor (row sum)
//   quotient   : registered quotient, holds until the next start
//   done       : high in the cycle that finishes (skip load or last iteration)
//   running    : iterations in progress
//   zero_den   : high with done when den was zero
module serial_udiv
  import softmax_normalizer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [EX_W-1:0]  num,
  input  logic [SUM_W-1:0] den,
  output logic [OUT_W-1:0] quotient,
  output logic             done,
  output logic             running,
  output logic             zero_den
);

  // Remainder is one bit wider than den so the shifted value never overflows.
  logic [SUM_W:0]   rem_q, rem_d;
  logic [OUT_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [SUM_W:0]   rem_sh_s;
  logic [SUM_W:0]   num_ext_s;
  logic [SUM_W:0]   den_ext_s;

  assign num_ext_s = {{(SUM_W + 1 - EX_W){1'b0}}, num};
  assign den_ext_s = {1'b0, den};
  assign rem_sh_s  = {rem_q[SUM_W-1:0], 1'b0};
  assign quotient  = quo_q;
  assign running   = run_q;

  // Load / iterate next-state logic of the restoring division.
  always_comb begin
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done     = 1'b0;
    zero_den = 1'b0;
    if (start) begin
      if (den == {SUM_W{1'b0}}) begin
        quo_d    = {OUT_W{1'b0}};
        done     = 1'b1;
        zero_den = 1'b1;
      end else if (num_ext_s >= den_ext_s) begin
        // Probability of 1.0 is not representable in UQ0.OUT_W; clamp.
        quo_d = {OUT_W{1'b1}};
        done  = 1'b1;
      end else begin
        rem_d = num_ext_s;
        quo_d = {OUT_W{1'b0}};
        cnt_d = CNT_W'(OUT_W - 1);
        run_d = 1'b1;
      end
    end else if (run_q) begin
      if (rem_sh_s >= den_ext_s) begin
        rem_d        = rem_sh_s - den_ext_s;
        quo_d[cnt_q] = 1'b1;
      end else begin
        rem_d = rem_sh_s;
      end
      if (cnt_q == {CNT_W{1'b0}}) begin
        run_d = 1'b0;
        done  = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= {(SUM_W + 1){1'b0}};
      quo_q <= {OUT_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/softmax_normalizer.sv
// Softmax normalizer: buffers one row of N_ELEM e^x values, accumulates their sum,
// then divides each buffered value by the sum and streams UQ0.8 probabilities.
// Only one row is in flight; the input and output phases never overlap.
// Ports:
//   clk, rst_n : clock, async active-low reset (a reset mid-row discards the row)
//   bus        : e^x input and probability output streams (slave side)
//   busy       : high while dividing or presenting results
//   div_zero   : last row summed to zero; sticky until the first accept of the next row
module softmax_normalizer
  import softmax_normalizer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  softmax_normalizer_if.slave  bus,
  output logic                 busy,
  output logic                 div_zero
);

  if (SUM_W < EX_W + clog2(N_ELEM)) begin : g_sum_w_check
    $error("SUM_W too narrow to hold a full row sum");
  end

  norm_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [EX_W-1:0]  row_buf_q [N_ELEM];
  logic [EX_W-1:0]  row_buf_d [N_ELEM];
  logic             div_zero_q, div_zero_d;
  logic             ex_rdy_q, ex_rdy_d;
  logic             prob_vld_q, prob_vld_d;
  logic             prob_last_q, prob_last_d;
  logic             busy_q, busy_d;

  logic             ex_acc_s;
  logic             prob_hs_s;
  logic             div_start_s;
  logic             div_done_s;
  logic             div_run_s;
  logic             div_zero_ev_s;
  logic [OUT_W-1:0] div_quo_s;
  logic [SUM_W-1:0] ex_ext_s;
  logic             idx_last_s;

  assign ex_acc_s    = bus.ex_vld & ex_rdy_q;
  assign prob_hs_s   = prob_vld_q & bus.prob_rdy;
  assign ex_ext_s    = {{(SUM_W - EX_W){1'b0}}, bus.ex_in};
  assign idx_last_s  = (idx_q == IDX_W'(N_ELEM - 1));
  // The divider is started once per element: on the first DIVIDE cycle, while it is idle.
  assign div_start_s = (state_q == DIVIDE) & ~div_run_s;

  serial_udiv u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_s),
    .num      (row_buf_q[idx_q]),
    .den      (sum_q),
    .quotient (div_quo_s),
    .done     (div_done_s),
    .running  (div_run_s),
    .zero_den (div_zero_ev_s)
  );

  // Row FSM: collect the row, divide each element, hand out each probability.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    row_buf_d  = row_buf_q;
    div_zero_d = div_zero_q;
    case (state_q)
      COLLECT: begin
        if (ex_acc_s) begin
          row_buf_d[idx_q] = bus.ex_in;
          if (idx_q == {IDX_W{1'b0}}) begin
            sum_d      = ex_ext_s;
            div_zero_d = 1'b0;
          end else begin
            sum_d = sum_q + ex_ext_s;
          end
          if (idx_last_s) begin
            idx_d   = {IDX_W{1'b0}};
            state_d = DIVIDE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = COLLECT;
        end
      end
      DIVIDE: begin
        if (div_zero_ev_s) begin
          div_zero_d = 1'b1;
        end else begin
          div_zero_d = div_zero_q;
        end
        if (div_done_s) begin
          state_d = OUTPUT;
        end else begin
          state_d = DIVIDE;
        end
      end
      OUTPUT: begin
        if (prob_hs_s) begin
          if (idx_last_s) begin
            state_d = COLLECT;
            sum_d   = {SUM_W{1'b0}};
            idx_d   = {IDX_W{1'b0}};
          end else begin
            state_d = DIVIDE;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = OUTPUT;
        end
      end
      default: begin
        state_d = COLLECT;
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Output flags are registered from the next state so they are glitch-free,
  // and ex_rdy only rises on the first clock after reset release.
  always_comb begin
    ex_rdy_d    = (state_d == COLLECT);
    prob_vld_d  = (state_d == OUTPUT);
    prob_last_d = (state_d == OUTPUT) && (idx_d == IDX_W'(N_ELEM - 1));
    busy_d      = (state_d == DIVIDE) || (state_d == OUTPUT);
  end

  // Control, accumulator, buffer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      idx_q       <= {IDX_W{1'b0}};
      sum_q       <= {SUM_W{1'b0}};
      div_zero_q  <= 1'b0;
      ex_rdy_q    <= 1'b0;
      prob_vld_q  <= 1'b0;
      prob_last_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < N_ELEM; i++) begin
        row_buf_q[i] <= {EX_W{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      div_zero_q  <= div_zero_d;
      ex_rdy_q    <= ex_rdy_d;
      prob_vld_q  <= prob_vld_d;
      prob_last_q <= prob_last_d;
      busy_q      <= busy_d;
      row_buf_q   <= row_buf_d;
    end
  end

  assign bus.ex_rdy    = ex_rdy_q;
  assign bus.prob_vld  = prob_vld_q;
  assign bus.prob_last = prob_last_q;
  assign bus.prob_out  = div_quo_s;
  assign busy          = busy_q;
  assign div_zero      = div_zero_q;

endmodule
